memory_arbiter: RTL



---
 rtl/memory_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port req/ack arbiter/sequencer in front of a shared
// 16-bit bidirectional memory. Each granted access walks IDLE -> ACCESS -> ACK,
// so at most one access completes every three cycles.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// left undefined, port 0 always wins a tie (fixed priority).
module memory_arbiter #(
    parameter int address_size = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    rw0,
    input  logic [address_size-1:0] addr0,
    input  logic [15:0]             wdata0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic                    rw1,
    input  logic [address_size-1:0] addr1,
    input  logic [15:0]             wdata1,
    output logic                    ack1,
    output logic [15:0]             rdata,
    output logic                    mem_enable,
    output logic                    mem_read_write,
    output logic [address_size-1:0] mem_address,
    inout  wire  [15:0]             mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t      state;
    logic        grant_port;   // port that owns the current access
    logic [15:0] wdata_q;      // write data latched at grant
    logic        pick1;        // 1 when port 1 wins the IDLE-edge arbitration

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        rr_last;      // last granted port; the other one wins a tie
`endif

    // The bus is driven only while a write access is in flight; the memory
    // owns it during reads, and it floats in every other cycle.
    assign mem_data = (mem_enable && !mem_read_write) ? wdata_q : 16'hzzzz;

    // Winner selection for the coming IDLE edge.
    always_comb begin
        // NOTE: default first so every path assigns pick1 and no latch is inferred.
        pick1 = 1'b0;
        if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick1 = ~rr_last;
`else
            pick1 = 1'b0;
`endif
        end else if (req1) begin
            pick1 = 1'b1;
        end
    end

    // Sequencer: grant in IDLE, run the memory cycle in ACCESS, pulse ack in ACK.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state          <= IDLE;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata          <= 16'h0000;
            mem_enable     <= 1'b0;
            mem_read_write <= 1'b1;
            mem_address    <= '0;
            grant_port     <= 1'b0;
            wdata_q        <= 16'h0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        grant_port     <= pick1;
                        mem_enable     <= 1'b1;
                        mem_read_write <= pick1 ? rw1 : rw0;
                        mem_address    <= pick1 ? addr1 : addr0;
                        wdata_q        <= pick1 ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_last        <= pick1;
`endif
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_read_write) begin
                        rdata <= mem_data;
                    end
                    mem_enable     <= 1'b0;
                    mem_read_write <= 1'b1;
                    ack0           <= ~grant_port;
                    ack1           <= grant_port;
                    state          <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
